food_seller: RTL and testbench
==============================

Name: food_seller

Overview:
- Single-transaction food vending controller. Six items, numbered 1..6, each with its own 3-bit stock counter.
- Each clock cycle it samples a selection and a deposited amount, then either dispenses the item or refunds.
- Registered outputs report the dispensed item, the remaining stock of that item, and the change returned.
- Top-level block of the FoodSeller design; drives display/dispense logic downstream.

Parameters:
- INIT_STOCK, 3, units of each item loaded on reset (legal 0..7).

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous, active-high reset
- choice  input  3  item selection: 0 = no selection, 1..6 = item, 7 = invalid
- money  input  3  amount deposited this cycle (0..7 units)
- item1  output  3  item dispensed this transaction; 0 = nothing dispensed
- available_item1  output  3  stock left of the selected item after this transaction
- remaining_money1  output  3  change or refund returned this transaction

Behaviour:
- One clock domain (clk); reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset (rst=1 at a rising edge):
  - all six stock counters <= INIT_STOCK
  - item1, available_item1, remaining_money1 <= 0
  - choice and money are ignored that cycle
  - rst takes priority over any purchase in the same cycle
- Prices are fixed: price(item n) = n units, so item1=1 ... item6=6.
- Every non-reset rising edge is one independent transaction. Latency is 1 cycle: outputs reflect the inputs sampled at the previous edge. No handshake and no money accumulation across cycles.
- Case choice in 1..6, stock[choice] > 0 and money >= price(choice) — sale:
  - item1 <= choice
  - stock[choice] <= stock[choice] - 1
  - available_item1 <= stock[choice] - 1 (post-decrement value)
  - remaining_money1 <= money - price(choice); arithmetic is 3-bit, never negative given the guard
- Case choice in 1..6, stock[choice] == 0 — sold out:
  - item1 <= 0; available_item1 <= 0; remaining_money1 <= money (full refund)
  - stock unchanged
- Case choice in 1..6, stock > 0, money < price — insufficient funds:
  - item1 <= 0; available_item1 <= stock[choice] (unchanged value); remaining_money1 <= money
  - stock unchanged
- Case choice == 0 or choice == 7 — idle/invalid:
  - item1 <= 0; available_item1 <= 0; remaining_money1 <= money
  - no stock changes
- Holding the same choice for several cycles buys once per cycle, until stock or funds run out. No edge detection.
- Stock counters never underflow; there is no restock path other than reset.
- Only the selected item's counter can change in a cycle.
- Reset mid-sequence discards any pending transaction and fully restocks all items.

Test Plan:
- Reset then nominal sequence: rst=1 for one edge, money=7 held.
  - Choices per edge: 1, 4, 5, 2, 1, 0.
  - Required (item1, available_item1, remaining_money1): (1,2,6), (4,2,3), (5,2,2), (2,2,5), (1,1,6), (0,0,7).
- Insufficient funds: after reset, money=3, choice=6 -> (0,3,3); then choice=3 -> (3,2,0).
- Sold out: after reset, money=7, choice=3 for four edges -> (3,2,4), (3,1,4), (3,0,4), (0,0,7).
- Invalid/idle: choice=7, money=5 -> (0,0,5); choice=0, money=0 -> (0,0,0); stock unchanged, verified by a later choice=1 giving available_item1=2.
- Reset priority/mid-operation: drain item 2 to stock 1, then assert rst with choice=2, money=7.
  - Outputs all 0, no sale.
  - Next edge with rst=0 and choice=2 -> (2,2,5).
- Exact-price boundary: money=6, choice=6 -> (6,2,0); money=0, choice=1 -> (0,3,0).

Source files
------------

// File: rtl/food_seller.sv
// Single-transaction vending controller: six items priced 1..6 units, per-item
// 3-bit stock, one independent purchase decision per clock with registered results.
module food_seller #(
    parameter int unsigned INIT_STOCK = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] choice,
    input  logic [2:0] money,
    output logic [2:0] item1,
    output logic [2:0] available_item1,
    output logic [2:0] remaining_money1
);

    localparam int unsigned N_ITEMS = 6;
    localparam logic [2:0]  INIT_Q  = 3'(INIT_STOCK);

    logic [2:0] stock_q [N_ITEMS];
    logic [2:0] stock_d [N_ITEMS];
    logic [2:0] item_q,   item_d;
    logic [2:0] avail_q,  avail_d;
    logic [2:0] change_q, change_d;

    logic       sel_valid;
    logic [2:0] sel_stock;

    // Price equals the item number, so choice doubles as the price operand.
    always_comb begin
        sel_valid = 1'b0;
        sel_stock = 3'd0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (choice == 3'(i + 1)) begin
                sel_valid = 1'b1;
                sel_stock = stock_q[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_ITEMS; i++) begin
            stock_d[i] = stock_q[i];
        end
        item_d   = 3'd0;
        avail_d  = 3'd0;
        change_d = money;

        if (sel_valid && sel_stock != 3'd0) begin
            if (money >= choice) begin
                item_d   = choice;
                avail_d  = sel_stock - 3'd1;
                change_d = money - choice;
                for (int i = 0; i < N_ITEMS; i++) begin
                    if (choice == 3'(i + 1)) begin
                        stock_d[i] = sel_stock - 3'd1;
                    end
                end
            end else begin
                avail_d = sel_stock;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_ITEMS; i++) begin
                stock_q[i] <= INIT_Q;
            end
            item_q   <= 3'd0;
            avail_q  <= 3'd0;
            change_q <= 3'd0;
        end else begin
            for (int i = 0; i < N_ITEMS; i++) begin
                stock_q[i] <= stock_d[i];
            end
            item_q   <= item_d;
            avail_q  <= avail_d;
            change_q <= change_d;
        end
    end

    assign item1            = item_q;
    assign available_item1  = avail_q;
    assign remaining_money1 = change_q;

endmodule

// File: tb/tb_food_seller.sv
// Self-checking bench for food_seller: directed purchase sequences with fixed
// expected results, then a randomized phase checked against a reference model.
module tb_food_seller;

    logic       clk;
    logic       rst;
    logic [2:0] choice;
    logic [2:0] money;
    logic [2:0] item1;
    logic [2:0] available_item1;
    logic [2:0] remaining_money1;

    typedef struct {
        logic [2:0] item;
        logic [2:0] avail;
        logic [2:0] change;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ms [1:6];

    food_seller #(.INIT_STOCK(3)) dut (
        .clk              (clk),
        .rst              (rst),
        .choice           (choice),
        .money            (money),
        .item1            (item1),
        .available_item1  (available_item1),
        .remaining_money1 (remaining_money1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one transaction, queue its expectation, then score the registered result.
    task automatic step(input string tag, input logic r, input logic [2:0] c,
                        input logic [2:0] m, input logic [2:0] e_item,
                        input logic [2:0] e_avail, input logic [2:0] e_chg);
        exp_t e;
        @(negedge clk);
        rst    = r;
        choice = c;
        money  = m;
        sb.push_back('{e_item, e_avail, e_chg, tag});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 3'd1, 3'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_item"},   item1,            e.item);
            chk({e.tag, "_avail"},  available_item1,  e.avail);
            chk({e.tag, "_change"}, remaining_money1, e.change);
        end
    endtask

    task automatic model_step(input string tag, input logic r, input logic [2:0] c,
                              input logic [2:0] m);
        int ci;
        int s;
        ci = int'(c);
        if (r) begin
            for (int k = 1; k <= 6; k++) ms[k] = 3;
            step(tag, 1'b1, c, m, 3'd0, 3'd0, 3'd0);
        end else if (ci < 1 || ci > 6) begin
            step(tag, 1'b0, c, m, 3'd0, 3'd0, m);
        end else begin
            s = ms[ci];
            if (s == 0) begin
                step(tag, 1'b0, c, m, 3'd0, 3'd0, m);
            end else if (int'(m) < ci) begin
                step(tag, 1'b0, c, m, 3'd0, 3'(s), m);
            end else begin
                ms[ci] = s - 1;
                step(tag, 1'b0, c, m, c, 3'(s - 1), 3'(int'(m) - ci));
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        choice = 3'd0;
        money  = 3'd0;

        // Nominal sequence
        step("rst0",   1'b1, 3'd5, 3'd7, 3'd0, 3'd0, 3'd0);
        step("nom_c1", 1'b0, 3'd1, 3'd7, 3'd1, 3'd2, 3'd6);
        step("nom_c4", 1'b0, 3'd4, 3'd7, 3'd4, 3'd2, 3'd3);
        step("nom_c5", 1'b0, 3'd5, 3'd7, 3'd5, 3'd2, 3'd2);
        step("nom_c2", 1'b0, 3'd2, 3'd7, 3'd2, 3'd2, 3'd5);
        step("nom_c1b",1'b0, 3'd1, 3'd7, 3'd1, 3'd1, 3'd6);
        step("nom_c0", 1'b0, 3'd0, 3'd7, 3'd0, 3'd0, 3'd7);

        // Insufficient funds
        step("rst1",   1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
        step("nsf_c6", 1'b0, 3'd6, 3'd3, 3'd0, 3'd3, 3'd3);
        step("nsf_c3", 1'b0, 3'd3, 3'd3, 3'd3, 3'd2, 3'd0);

        // Sold out
        step("rst2",   1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
        step("so_1",   1'b0, 3'd3, 3'd7, 3'd3, 3'd2, 3'd4);
        step("so_2",   1'b0, 3'd3, 3'd7, 3'd3, 3'd1, 3'd4);
        step("so_3",   1'b0, 3'd3, 3'd7, 3'd3, 3'd0, 3'd4);
        step("so_4",   1'b0, 3'd3, 3'd7, 3'd0, 3'd0, 3'd7);

        // Invalid / idle, stock untouched
        step("rst3",   1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
        step("inv_c7", 1'b0, 3'd7, 3'd5, 3'd0, 3'd0, 3'd5);
        step("idle_c0",1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
        step("inv_chk",1'b0, 3'd1, 3'd7, 3'd1, 3'd2, 3'd6);

        // Reset priority mid-operation
        step("rst4",   1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
        step("rp_d1",  1'b0, 3'd2, 3'd7, 3'd2, 3'd2, 3'd5);
        step("rp_d2",  1'b0, 3'd2, 3'd7, 3'd2, 3'd1, 3'd5);
        step("rp_rst", 1'b1, 3'd2, 3'd7, 3'd0, 3'd0, 3'd0);
        step("rp_buy", 1'b0, 3'd2, 3'd7, 3'd2, 3'd2, 3'd5);

        // Exact-price and zero-money boundaries
        step("rst5",   1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
        step("ex_c6",  1'b0, 3'd6, 3'd6, 3'd6, 3'd2, 3'd0);
        step("ex_m0",  1'b0, 3'd1, 3'd0, 3'd0, 3'd3, 3'd0);

        // Randomized phase against reference model
        model_step("rnd_rst", 1'b1, 3'd0, 3'd0);
        for (int n = 0; n < 200; n++) begin
            model_step($sformatf("rnd%0d", n), ($urandom_range(0, 31) == 0),
                       3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        if (sb.size() != 0) chk("sb_leftover", 3'(sb.size()), 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
